cntr_down_timer: RTL and testbench
==================================

// Module: cntr_down_timer
// PURPOSE
//  Loadable W-bit down-counter/timer; the counting-down counterpart of the team's free-running up counters.
//  A value is accepted over a valid/ready load handshake, then decremented once per enable tick.
//  tc pulses when the count expires; modes are one-shot or auto-reload (periodic).
//  Sits beside the up counters in measurement datapaths: gate windows, timeouts, periodic strobes.
// PARAMETERS
//  W         16  counter / load_value / out width (bits), >= 2
//  PRESCALE  4   ce pulses per decrement tick; used only when CNTR_PRESCALER_EN is defined; >= 1
// PORTS
//  clk          in   1  clock; all logic on posedge clk
//  rst          in   1  reset, synchronous, active-high
//  ce           in   1  count enable; one decrement candidate per cycle it is high
//  load_valid   in   1  load request
//  load_ready   out  1  high when a load can be accepted (state IDLE)
//  load_value   in   W  start count N, sampled on acceptance
//  auto_reload  in   1  mode, sampled on acceptance: 1 = periodic, 0 = one-shot
//  stop         in   1  abort a running count
//  out          out  W  current count (registered)
//  tc           out  1  terminal-count pulse, exactly one cycle wide (registered)
//  busy         out  1  high in state RUN
// BEHAVIOUR
//  Reset: state=IDLE, out=0, tc=0, reload_reg=0, mode_reg=0, prescaler=0; hence load_ready=1, busy=0.
//  rst wins over every other input, including mid-run; tc is never emitted from the reset cycle.
//  States: IDLE -> RUN on accept (load_valid && load_ready && load_value!=0).
//   RUN -> IDLE on stop, or on expiry in one-shot mode. RUN -> RUN on expiry in auto-reload mode.
//  Accept: out<=load_value, reload_reg<=load_value, mode_reg<=auto_reload, prescaler cleared.
//   A ce in the accept cycle does not decrement.
//  load_value==0 accepted in IDLE: out<=0, tc<=1 next cycle, state stays IDLE.
//  load_valid in RUN: load_ready=0, request ignored; out and state unaffected.
//  tick = ce when CNTR_PRESCALER_EN is not defined (see CONFIGURATION).
//  RUN, tick, out>1: out<=out-1.
//  RUN, tick, out==1 (expiry): tc<=1 for one cycle.
//   one-shot: out<=0, state<=IDLE.
//   auto-reload: out<=reload_reg, stay RUN; period = N ticks; the 0 value is never shown.
//  Latency: N ticks from accept to the first tc; tc becomes visible in the cycle after the Nth tick.
//  stop in RUN: state<=IDLE next cycle, out holds its value, tc not asserted.
//   stop and expiry tick in the same cycle: stop wins, no tc, out holds.
//  stop in IDLE: no effect.
//  No wrap-around: out never decrements below 0. Arithmetic is unsigned W-bit.
//  tc cleared every cycle it is not explicitly set.
// CONFIGURATION
//  CNTR_PRESCALER_EN defined:
//   internal counter of width clog2(PRESCALE) counts ce pulses;
//   tick = ce && (prescaler==PRESCALE-1); the prescaler wraps to 0 on that cycle.
//   Prescaler cleared on rst and on accept; it holds in IDLE.
//   Effective period = N*PRESCALE ce pulses.
//  CNTR_PRESCALER_EN undefined: tick = ce; PRESCALE ignored; no prescaler logic synthesised.
// STRUCTURE
//  Shared package/include cntr_pkg: state encodings ST_IDLE=1'b0, ST_RUN=1'b1; mode constants
//   MODE_ONESHOT=0, MODE_RELOAD=1; used by all counter/timer blocks.
//  One natural sub-module: cntr_prescaler (ce in, clear in, tick out),
//   instantiated only under CNTR_PRESCALER_EN.
//  Top: FSM + count register + reload/mode registers + tc register.
// TESTING (macro undefined unless noted)
//  1 Load 3, one-shot, ce=1 continuous -> out 3,2,1,0; tc high the cycle out=0; busy falls same cycle.
//  2 Load 2, auto-reload, ce=1 -> out 2,1,2,1,...; tc every 2nd cycle, busy stays 1; then stop -> IDLE, out holds.
//  3 Load 5, ce toggling 1/0, stop asserted when out==1 with ce=1 -> no tc, out=1, load_ready=1 next cycle.
//  4 load_value=0 in IDLE -> tc one cycle after accept, out=0, busy never high;
//    load_valid=1 during RUN -> ignored, load_ready=0.
//  5 rst mid-run (out=7) -> next cycle out=0, tc=0, busy=0, load_ready=1; a ce in the rst cycle has no effect.
//  6 CNTR_PRESCALER_EN, PRESCALE=4, load 2 one-shot, ce=1 -> tc exactly 8 ce cycles after accept; out changes every 4 cycles.

Source files
------------

// File: rtl/cntr_down_timer_pkg.sv
// ----------------------------------------------------------------------------
// cntr_down_timer_pkg
// Shared definitions for the counter/timer blocks:
//   - state_t      : timer FSM encoding (ST_IDLE = 1'b0, ST_RUN = 1'b1)
//   - MODE_*       : expiry behaviour sampled at load time
//   - width_min1() : counter width helper that never returns zero
// Optional feature macro used by the blocks that import this package:
//   CNTR_PRESCALER_EN
// ----------------------------------------------------------------------------
package cntr_down_timer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

    // Bits needed to count 0..v-1. A divide-by-one prescaler still gets a
    // one-bit register so the port/array widths stay legal.
    function automatic int width_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/cntr_down_timer_if.sv
// ----------------------------------------------------------------------------
// cntr_down_timer_if
// Load handshake bundle for the down timer.
//   load_valid   master -> slave  load request
//   load_ready   slave  -> master load can be accepted (timer idle)
//   load_value   master -> slave  start count N, sampled on acceptance
//   auto_reload  master -> slave  1 = periodic, 0 = one-shot, sampled on acceptance
// Parameter W: width of load_value.
// ----------------------------------------------------------------------------
interface cntr_down_timer_if #(
    parameter int W = 16
);
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_value;
    logic         auto_reload;

    modport master (
        output load_valid,
        output load_value,
        output auto_reload,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_value,
        input  auto_reload,
        output load_ready
    );
endinterface

// File: rtl/cntr_down_timer_prescaler.sv
// ----------------------------------------------------------------------------
// cntr_down_timer_prescaler
// Divides count-enable pulses by PRESCALE: tick is high on the ce pulse that
// completes each group of PRESCALE pulses. Only built into the timer when
// CNTR_PRESCALER_EN is defined.
// Ports:
//   clk    in  clock
//   rst    in  synchronous active-high reset (clears the count)
//   ce     in  pulse to be counted
//   clear  in  restart the group count (takes priority over ce)
//   tick   out one pulse per PRESCALE ce pulses (combinational from ce)
// ----------------------------------------------------------------------------
module cntr_down_timer_prescaler
    import cntr_down_timer_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic clear,
    output logic tick
);
    localparam int PW = width_min1(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] count_reg;

    assign tick = ce && (count_reg == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (ce) begin
            count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
        end
    end
endmodule

// File: rtl/cntr_down_timer.sv
// ----------------------------------------------------------------------------
// cntr_down_timer
// Loadable W-bit down counter / timer. A start value N is accepted over the
// load handshake while idle, then decremented once per tick. tc pulses for one
// cycle when the count expires; one-shot mode returns to idle with out = 0,
// auto-reload mode reloads N and keeps running (period = N ticks).
// Macro CNTR_PRESCALER_EN: when defined, a tick is every PRESCALE-th ce pulse
// seen while running; otherwise tick = ce and PRESCALE is unused.
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset
//   ce    in   count enable
//   stop  in   abort a running count (out holds, no tc)
//   ld    slave load handshake (load_valid/load_ready/load_value/auto_reload)
//   out   out  current count (registered)
//   tc    out  terminal-count pulse, one cycle (registered)
//   busy  out  high while running
// ----------------------------------------------------------------------------
module cntr_down_timer
    import cntr_down_timer_pkg::*;
#(
    parameter int W        = 16,
    parameter int PRESCALE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic                stop,
    cntr_down_timer_if.slave    ld,
    output logic [W-1:0]        out,
    output logic                tc,
    output logic                busy
);
    // Elaboration-time parameter sanity.
    generate
        if (W < 2) begin : g_bad_w
            $error("cntr_down_timer: W must be >= 2");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("cntr_down_timer: PRESCALE must be >= 1");
        end
    endgenerate

    state_t       state_reg;
    logic [W-1:0] out_reg;
    logic [W-1:0] reload_reg;
    logic         mode_reg;
    logic         tc_reg;
    logic         tick;

`ifdef CNTR_PRESCALER_EN
    logic accept;
    assign accept = (state_reg == ST_IDLE) && ld.load_valid && (ld.load_value != '0);

    // Only ce pulses seen while running advance the prescaler, so it holds in
    // idle; each accepted load restarts it from zero.
    cntr_down_timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce && (state_reg == ST_RUN)),
        .clear (accept),
        .tick  (tick)
    );
`else
    assign tick = ce;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            out_reg    <= '0;
            reload_reg <= '0;
            mode_reg   <= MODE_ONESHOT;
            tc_reg     <= 1'b0;
        end else begin
            tc_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (ld.load_valid) begin
                        if (ld.load_value == '0) begin
                            // Zero-length count expires immediately and never runs.
                            out_reg <= '0;
                            tc_reg  <= 1'b1;
                        end else begin
                            out_reg    <= ld.load_value;
                            reload_reg <= ld.load_value;
                            mode_reg   <= ld.auto_reload;
                            state_reg  <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // stop beats a simultaneous expiry: no tc, count frozen.
                    if (stop) begin
                        state_reg <= ST_IDLE;
                    end else if (tick) begin
                        if (out_reg > W'(1)) begin
                            out_reg <= out_reg - 1'b1;
                        end else begin
                            // out is never 0 while running, so this is out == 1.
                            tc_reg <= 1'b1;
                            if (mode_reg == MODE_RELOAD) begin
                                out_reg <= reload_reg;
                            end else begin
                                out_reg   <= '0;
                                state_reg <= ST_IDLE;
                            end
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign out           = out_reg;
    assign tc            = tc_reg;
    assign busy          = (state_reg == ST_RUN);
    assign ld.load_ready = (state_reg == ST_IDLE);
endmodule

// File: tb/tb_cntr_down_timer.sv
// ----------------------------------------------------------------------------
// tb_cntr_down_timer
// Drives the down timer with directed scenarios followed by random traffic and
// compares out/tc/busy/load_ready every cycle against a reference model that
// describes the timer by how many ticks have elapsed since the load.
// ----------------------------------------------------------------------------
module tb_cntr_down_timer;
    localparam int W        = 16;
    localparam int PRESCALE = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         ce;
    logic         stop;
    logic [W-1:0] out;
    logic         tc;
    logic         busy;

    cntr_down_timer_if #(.W(W)) ld_if ();

    cntr_down_timer #(
        .W        (W),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .ce   (ce),
        .stop (stop),
        .ld   (ld_if.slave),
        .out  (out),
        .tc   (tc),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a run is described by its length N, mode and the number
    // of ticks elapsed since the load. The shown count follows from that.
    bit           m_run     = 1'b0;
    bit           m_reload  = 1'b0;
    int           m_n       = 0;
    int           m_ticks   = 0;
    int           m_ces     = 0;
    logic [W-1:0] m_idle_out = '0;
    bit           m_tc      = 1'b0;

    function automatic logic [W-1:0] m_out();
        if (!m_run) return m_idle_out;
        if (m_reload) return W'(m_n - (m_ticks % m_n));
        return W'(m_n - m_ticks);
    endfunction

    function automatic bit m_is_tick(input bit c);
`ifdef CNTR_PRESCALER_EN
        return c && (((m_ces + 1) % PRESCALE) == 0);
`else
        return c;
`endif
    endfunction

    task automatic model_step(input bit r, input bit c, input bit s, input bit lv,
                              input logic [W-1:0] val, input bit ar);
        if (r) begin
            m_run = 1'b0; m_idle_out = '0; m_tc = 1'b0;
            return;
        end
        m_tc = 1'b0;
        if (!m_run) begin
            if (lv) begin
                if (val == '0) begin
                    m_idle_out = '0; m_tc = 1'b1;
                end else begin
                    m_run = 1'b1; m_n = int'(val); m_reload = ar;
                    m_ticks = 0; m_ces = 0;
                end
            end
        end else if (s) begin
            m_idle_out = m_out();
            m_run = 1'b0;
        end else begin
            if (m_is_tick(c)) begin
                m_ticks++;
                if (m_ticks % m_n == 0) begin
                    m_tc = 1'b1;
                    if (!m_reload) begin
                        m_run = 1'b0; m_idle_out = '0;
                    end
                end
            end
            if (c) m_ces++;
        end
    endtask

    // One clock: drive inputs mid-cycle, advance the model, check after the edge.
    task automatic step(input bit r, input bit c, input bit s, input bit lv,
                        input logic [W-1:0] val, input bit ar, input string tag);
        @(negedge clk);
        rst = r; ce = c; stop = s;
        ld_if.load_valid = lv; ld_if.load_value = val; ld_if.auto_reload = ar;
        model_step(r, c, s, lv, val, ar);
        @(posedge clk);
        #1;
        $display("%s rst=%0b ce=%0b stop=%0b lv=%0b val=%0d ar=%0b -> out=%0d tc=%0b busy=%0b rdy=%0b",
                 tag, r, c, s, lv, val, ar, out, tc, busy, ld_if.load_ready);
        check({tag, ".out"},  32'(out),              32'(m_out()));
        check({tag, ".tc"},   32'(tc),               32'(m_tc));
        check({tag, ".busy"}, 32'(busy),             32'(m_run));
        check({tag, ".rdy"},  32'(ld_if.load_ready), 32'(!m_run));
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; stop = 1'b0;
        ld_if.load_valid = 1'b0; ld_if.load_value = '0; ld_if.auto_reload = 1'b0;

        step(1, 0, 0, 0, 0, 0, "reset");
        step(1, 1, 0, 1, 16'd9, 1, "reset");
        step(0, 0, 0, 0, 0, 0, "idle");

`ifdef CNTR_PRESCALER_EN
        // Load 2 one-shot, ce continuous: tc after 8 ce cycles.
        step(0, 1, 0, 1, 16'd2, 0, "pre_load");
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 0, "pre_run");
`else
        // One-shot 3 with continuous ce.
        step(0, 1, 0, 1, 16'd3, 0, "t1_load");
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, "t1_run");
        check("t1.out_zero", 32'(out), 32'd0);

        // Auto-reload 2, then stop.
        step(0, 1, 0, 1, 16'd2, 1, "t2_load");
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0, "t2_run");
        step(0, 1, 1, 0, 0, 0, "t2_stop");
        step(0, 1, 0, 0, 0, 0, "t2_idle");
`endif

        // Load 5, toggling ce, stop on the expiry tick.
        step(0, 0, 0, 1, 16'd5, 0, "t3_load");
        for (int i = 0; i < 40 && m_out() != 1; i++) step(0, i[0], 0, 0, 0, 0, "t3_run");
        check("t3.reached_one", 32'(m_out()), 32'd1);
        step(0, 1, 1, 0, 0, 0, "t3_stop");
        step(0, 1, 0, 0, 0, 0, "t3_after");

        // Zero load, then a load request ignored while running.
        step(0, 1, 0, 1, 16'd0, 0, "t4_zero");
        step(0, 0, 0, 0, 0, 0, "t4_after");
        step(0, 0, 0, 1, 16'd4, 0, "t4_load");
        step(0, 0, 0, 1, 16'd9, 1, "t4_ignored");
        step(0, 0, 1, 0, 0, 0, "t4_stop");

        // Reset mid-run at out=7 with ce high.
        step(0, 0, 0, 1, 16'd10, 1, "t5_load");
        for (int i = 0; i < 60 && m_out() != 7; i++) step(0, 1, 0, 0, 0, 0, "t5_run");
        step(1, 1, 0, 0, 0, 0, "t5_rst");
        step(0, 0, 0, 0, 0, 0, "t5_after");

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit           r, c, s, lv, ar;
            logic [W-1:0] val;
            r  = ($urandom_range(0, 99) == 0);
            c  = ($urandom_range(0, 3) != 0);
            s  = ($urandom_range(0, 19) == 0);
            lv = ($urandom_range(0, 3) == 0);
            ar = $urandom_range(0, 1) != 0;
            case ($urandom_range(0, 7))
                0:       val = '0;
                1:       val = W'($urandom_range(1, 40));
                default: val = W'($urandom_range(1, 6));
            endcase
            step(r, c, s, lv, val, ar, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
